// File: rtl/forward_scoreboard_pkg.sv
// rtl/forward_scoreboard_pkg.sv - shared register type and bypass-select constants
package rvga_types;

    typedef logic [4:0] rvga_reg;

    // Bypass select base values; stage k maps to FWD_STAGE_BASE + k.
    localparam int FWD_RF         = 0;
    localparam int FWD_STAGE_BASE = 1;

    function automatic int fwd_sel_w(input int num_stages);
        return $clog2(num_stages + 2);
    endfunction

endpackage

// File: rtl/rvga_scoreboard.sv
// rtl/rvga_scoreboard.sv - pending bit per register for long-latency destinations
module rvga_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_W    = 5
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                set_v_i,
    input  logic [REG_W-1:0]    set_rd_i,
    input  logic                clr_v_i,
    input  logic [REG_W-1:0]    clr_rd_i,
    output logic [NUM_REGS-1:0] pending_o
);

    // A set and clear of the same register in one cycle leaves it pending:
    // the new issue outlives the old completion.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pending_o <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (set_v_i && set_rd_i == REG_W'(i))
                    pending_o[i] <= 1'b1;
                else if (clr_v_i && clr_rd_i == REG_W'(i))
                    pending_o[i] <= 1'b0;
            end
            pending_o[0] <= 1'b0;
        end
    end

endmodule

// File: rtl/forward_scoreboard.sv
// rtl/forward_scoreboard.sv - execute operand bypass select, stall generation and stall counter
module forward_scoreboard
    import rvga_types::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 2,
    parameter int NUM_REGS   = 32,
    parameter int REG_W      = 5,
    parameter int CNT_W      = 32,
    parameter int SEL_W      = fwd_sel_w(NUM_STAGES)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [NUM_STAGES-1:0]       stage_rd_w_v_i,
    input  logic [NUM_STAGES*REG_W-1:0] stage_rd_i,
    input  logic [NUM_STAGES-1:0]       stage_rd_ready_i,
    input  logic [NUM_SRC*REG_W-1:0]    execute_rs_i,
    input  logic [NUM_SRC-1:0]          execute_rs_v_i,
    input  logic [REG_W-1:0]            execute_rd_i,
    input  logic                        execute_rd_w_v_i,
    input  logic                        lat_issue_v_i,
    input  logic                        lat_complete_v_i,
    input  logic [REG_W-1:0]            lat_complete_rd_i,
    input  logic                        cnt_clear_i,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel_o,
    output logic                        stall_o,
    output logic [NUM_REGS-1:0]         pending_o,
    output logic [CNT_W-1:0]            stall_count_o
);

    logic [NUM_SRC-1:0] src_stall;
    logic               waw_stall;
    logic               sb_set_v;

    for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
        logic [REG_W-1:0] rs;
        logic             rs_act;
        logic [SEL_W-1:0] sel;
        logic             stage_hit;
        logic             bus_hit;
        logic             hit_ready;

        assign rs     = execute_rs_i[j*REG_W +: REG_W];
        assign rs_act = execute_rs_v_i[j] && (rs != '0);

        // Walk oldest to youngest so the youngest matching stage wins.
        always_comb begin
            sel       = SEL_W'(FWD_RF);
            stage_hit = 1'b0;
            bus_hit   = 1'b0;
            hit_ready = 1'b1;
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (stage_rd_w_v_i[k] && stage_rd_i[k*REG_W +: REG_W] == rs) begin
                    sel       = SEL_W'(FWD_STAGE_BASE + k);
                    stage_hit = 1'b1;
                    hit_ready = stage_rd_ready_i[k];
                end
            end
            if (!stage_hit && lat_complete_v_i && lat_complete_rd_i == rs) begin
                sel     = SEL_W'(NUM_STAGES + 1);
                bus_hit = 1'b1;
            end
            if (!rs_act) begin
                sel       = SEL_W'(FWD_RF);
                stage_hit = 1'b0;
                bus_hit   = 1'b0;
            end
        end

        assign fwd_sel_o[j*SEL_W +: SEL_W] = sel;
        assign src_stall[j] = rs_act &&
                              ((stage_hit && !hit_ready) ||
                               (!stage_hit && !bus_hit && pending_o[rs]));
    end

    assign waw_stall = execute_rd_w_v_i && (execute_rd_i != '0) && pending_o[execute_rd_i] &&
                       !(lat_complete_v_i && lat_complete_rd_i == execute_rd_i);

    assign stall_o  = (|src_stall) || waw_stall;
    assign sb_set_v = lat_issue_v_i && execute_rd_w_v_i && !stall_o && (execute_rd_i != '0);

    rvga_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .REG_W    (REG_W)
    ) u_scoreboard (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .set_v_i   (sb_set_v),
        .set_rd_i  (execute_rd_i),
        .clr_v_i   (lat_complete_v_i),
        .clr_rd_i  (lat_complete_rd_i),
        .pending_o (pending_o)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            stall_count_o <= '0;
        else if (cnt_clear_i)
            stall_count_o <= '0;
        else if (stall_o && stall_count_o != '1)
            stall_count_o <= stall_count_o + 1'b1;
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
// tb/tb_forward_scoreboard.sv - directed self-checking bench for forward_scoreboard
module tb_forward_scoreboard;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [1:0]  stage_rd_w_v_i;
    logic [9:0]  stage_rd_i;
    logic [1:0]  stage_rd_ready_i;
    logic [9:0]  execute_rs_i;
    logic [1:0]  execute_rs_v_i;
    logic [4:0]  execute_rd_i;
    logic        execute_rd_w_v_i;
    logic        lat_issue_v_i;
    logic        lat_complete_v_i;
    logic [4:0]  lat_complete_rd_i;
    logic        cnt_clear_i;
    logic [3:0]  fwd_sel_o;
    logic        stall_o;
    logic [31:0] pending_o;
    logic [3:0]  stall_count_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    forward_scoreboard #(
        .NUM_SRC    (2),
        .NUM_STAGES (2),
        .NUM_REGS   (32),
        .REG_W      (5),
        .CNT_W      (4)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .stage_rd_w_v_i    (stage_rd_w_v_i),
        .stage_rd_i        (stage_rd_i),
        .stage_rd_ready_i  (stage_rd_ready_i),
        .execute_rs_i      (execute_rs_i),
        .execute_rs_v_i    (execute_rs_v_i),
        .execute_rd_i      (execute_rd_i),
        .execute_rd_w_v_i  (execute_rd_w_v_i),
        .lat_issue_v_i     (lat_issue_v_i),
        .lat_complete_v_i  (lat_complete_v_i),
        .lat_complete_rd_i (lat_complete_rd_i),
        .cnt_clear_i       (cnt_clear_i),
        .fwd_sel_o         (fwd_sel_o),
        .stall_o           (stall_o),
        .pending_o         (pending_o),
        .stall_count_o     (stall_count_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stage_rd_w_v_i    = '0;
        stage_rd_i        = '0;
        stage_rd_ready_i  = '0;
        execute_rs_i      = '0;
        execute_rs_v_i    = '0;
        execute_rd_i      = '0;
        execute_rd_w_v_i  = 1'b0;
        lat_issue_v_i     = 1'b0;
        lat_complete_v_i  = 1'b0;
        lat_complete_rd_i = '0;
        cnt_clear_i       = 1'b0;
    endtask

    initial begin
        idle();
        reset_i = 1'b1;
        #12;
        chk("reset_pending", pending_o, 32'h0);
        chk("reset_count", {28'h0, stall_count_o}, 32'd0);
        chk("reset_sel", {28'h0, fwd_sel_o}, 32'd0);
        chk("reset_stall", {31'h0, stall_o}, 32'd0);
        tick();
        reset_i = 1'b0;
        tick();

        // Stage priority
        stage_rd_w_v_i   = 2'b11;
        stage_rd_ready_i = 2'b11;
        stage_rd_i       = {5'd3, 5'd3};
        execute_rs_i     = {5'd0, 5'd3};
        execute_rs_v_i   = 2'b01;
        #1;
        chk("prio_both_sel0", {30'h0, fwd_sel_o[1:0]}, 32'd1);
        chk("prio_both_stall", {31'h0, stall_o}, 32'd0);
        stage_rd_i = {5'd3, 5'd4};
        #1;
        chk("prio_stage1_sel0", {30'h0, fwd_sel_o[1:0]}, 32'd2);
        stage_rd_i   = {5'd3, 5'd0};
        execute_rs_i = {5'd0, 5'd0};
        #1;
        chk("x0_sel0", {30'h0, fwd_sel_o[1:0]}, 32'd0);
        execute_rs_i   = {5'd0, 5'd3};
        execute_rs_v_i = 2'b00;
        #1;
        chk("invalid_src_sel0", {30'h0, fwd_sel_o[1:0]}, 32'd0);

        // Load-use
        idle();
        stage_rd_w_v_i   = 2'b01;
        stage_rd_i       = {5'd0, 5'd7};
        stage_rd_ready_i = 2'b00;
        execute_rs_i     = {5'd7, 5'd0};
        execute_rs_v_i   = 2'b10;
        #1;
        chk("load_use_stall", {31'h0, stall_o}, 32'd1);
        tick();
        chk("load_use_cnt1", {28'h0, stall_count_o}, 32'd1);
        tick();
        chk("load_use_cnt2", {28'h0, stall_count_o}, 32'd2);
        stage_rd_ready_i = 2'b01;
        #1;
        chk("load_ready_stall", {31'h0, stall_o}, 32'd0);
        chk("load_ready_sel1", {30'h0, fwd_sel_o[3:2]}, 32'd1);
        tick();
        chk("load_ready_cnt", {28'h0, stall_count_o}, 32'd2);

        // Long-latency issue and completion
        idle();
        execute_rd_i     = 5'd9;
        execute_rd_w_v_i = 1'b1;
        lat_issue_v_i    = 1'b1;
        #1;
        chk("issue_stall", {31'h0, stall_o}, 32'd0);
        tick();
        chk("issue_pending9", pending_o, 32'h0000_0200);
        idle();
        execute_rs_i   = {5'd0, 5'd9};
        execute_rs_v_i = 2'b01;
        #1;
        chk("pending_raw_stall", {31'h0, stall_o}, 32'd1);
        tick();
        chk("pending_raw_cnt", {28'h0, stall_count_o}, 32'd3);
        chk("pending_raw_stall2", {31'h0, stall_o}, 32'd1);
        lat_complete_v_i  = 1'b1;
        lat_complete_rd_i = 5'd9;
        #1;
        chk("complete_sel_bus", {30'h0, fwd_sel_o[1:0]}, 32'd3);
        chk("complete_stall", {31'h0, stall_o}, 32'd0);
        tick();
        chk("complete_pending", pending_o, 32'h0);
        chk("complete_cnt", {28'h0, stall_count_o}, 32'd3);

        // Completion to a non-pending register
        idle();
        lat_complete_v_i  = 1'b1;
        lat_complete_rd_i = 5'd12;
        tick();
        chk("complete_nonpending", pending_o, 32'h0);

        // Simultaneous set and clear, then WAW
        idle();
        execute_rd_i     = 5'd9;
        execute_rd_w_v_i = 1'b1;
        lat_issue_v_i    = 1'b1;
        tick();
        chk("reissue_pending9", pending_o, 32'h0000_0200);
        lat_complete_v_i  = 1'b1;
        lat_complete_rd_i = 5'd9;
        #1;
        chk("simul_no_waw", {31'h0, stall_o}, 32'd0);
        tick();
        chk("simul_set_wins", pending_o, 32'h0000_0200);
        lat_complete_v_i = 1'b0;
        #1;
        chk("waw_stall", {31'h0, stall_o}, 32'd1);
        tick();
        chk("waw_cnt", {28'h0, stall_count_o}, 32'd4);
        chk("waw_pending", pending_o, 32'h0000_0200);
        execute_rd_i   = 5'd10;
        execute_rs_i   = {5'd0, 5'd9};
        execute_rs_v_i = 2'b01;
        #1;
        chk("issue_during_stall", {31'h0, stall_o}, 32'd1);
        tick();
        chk("issue_stalled_pending", pending_o, 32'h0000_0200);
        chk("issue_stalled_cnt", {28'h0, stall_count_o}, 32'd5);

        // Counter saturation and clear while stalled
        for (int i = 0; i < 16; i++) tick();
        chk("cnt_saturate", {28'h0, stall_count_o}, 32'd15);
        cnt_clear_i = 1'b1;
        tick();
        chk("cnt_clear", {28'h0, stall_count_o}, 32'd0);
        cnt_clear_i = 1'b0;
        tick();
        chk("cnt_after_clear", {28'h0, stall_count_o}, 32'd1);

        // Asynchronous reset mid-operation
        #2;
        reset_i = 1'b1;
        #1;
        chk("async_rst_pending", pending_o, 32'h0);
        chk("async_rst_cnt", {28'h0, stall_count_o}, 32'd0);
        tick();
        reset_i = 1'b0;
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/forward_scoreboard.md
Name: forward_scoreboard

Overview:
- Parametrised successor to the execute-stage forwarding logic.
- Generalises bypass to NUM_SRC source operands and NUM_STAGES downstream pipeline stages, plus a bypass from the completion bus of a long-latency unit (divider/multiplier).
- Adds a per-register pending scoreboard for long-latency ops, load-use / not-ready stall generation, WAW stall, and a saturating stall-cycle counter.
- Sits beside the execute stage; its outputs drive the execute operand muxes and the pipeline stall control.

Parameters:
- NUM_SRC, 2, number of execute source operands checked.
- NUM_STAGES, 2, downstream stages with a write port (index 0 = youngest, e.g. memory; 1 = writeback).
- NUM_REGS, 32, architectural registers.
- REG_W, 5, register address width (= $clog2(NUM_REGS)).
- CNT_W, 32, stall counter width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous active-high reset.
- stage_rd_w_v_i  in  NUM_STAGES  stage k writes a register.
- stage_rd_i  in  NUM_STAGES*REG_W  destination register of stage k.
- stage_rd_ready_i  in  NUM_STAGES  stage k result is available for bypass (0 for a load still in memory).
- execute_rs_i  in  NUM_SRC*REG_W  execute source registers.
- execute_rs_v_i  in  NUM_SRC  source j is actually read.
- execute_rd_i  in  REG_W  execute destination register.
- execute_rd_w_v_i  in  1  execute instruction writes rd.
- lat_issue_v_i  in  1  long-latency op issued from execute this cycle (only counts when stall_o=0).
- lat_complete_v_i  in  1  long-latency result on completion bus.
- lat_complete_rd_i  in  REG_W  completing destination register.
- cnt_clear_i  in  1  synchronous clear of stall counter.
- fwd_sel_o  out  NUM_SRC*SEL_W  per-source bypass select, SEL_W = $clog2(NUM_STAGES+2).
- stall_o  out  1  hold execute and earlier stages.
- pending_o  out  NUM_REGS  scoreboard state (debug/verification).
- stall_count_o  out  CNT_W  cycles with stall_o=1.

Behaviour:
- Reset (async, reset_i=1): pending = 0, stall_count_o = 0. fwd_sel_o and stall_o are combinational, so they are 0 when all valids are 0.
- fwd_sel encoding: 0 = register file, k+1 = stage k, NUM_STAGES+1 = completion bus.
- Per source j, only when execute_rs_v_i[j]=1 and rs≠0. Priority:
  - Lowest-index stage k with rd_w_v=1 and rd==rs.
  - Else completion bus if lat_complete_v_i=1 and lat_complete_rd_i==rs.
  - Else 0.
  - Register 0 never matches; the result is 0 when the source is invalid.
- Stall terms, OR-ed and combinational:
  - (a) Selected stage match has stage_rd_ready_i=0.
  - (b) pending[rs]=1, rs valid and ≠0, and no stage or completion match for rs.
  - (c) WAW: execute_rd_w_v_i=1, rd≠0, pending[rd]=1, and not completing this cycle.
- Scoreboard update on the clock edge:
  - Clear pending[lat_complete_rd_i] when lat_complete_v_i=1.
  - Set pending[execute_rd_i] when lat_issue_v_i & execute_rd_w_v_i & ~stall_o & rd≠0.
  - Same register set and cleared in one cycle: set wins.
  - Completion to a non-pending register is harmless (bit stays 0).
  - pending[0] is always 0.
- Counter:
  - cnt_clear_i has priority and loads 0.
  - Else increments when stall_o=1, saturating at all-ones (no wrap).
- Latency: forwarding/stall 0 cycles (combinational); scoreboard and counter take effect the following cycle.

Decomposition:
- rvga_types package: rvga_reg (already shared), plus a new fwd_sel enum base constants (FWD_RF=0) and a function computing SEL_W.
- Natural sub-module: rvga_scoreboard (pending bit-vector with set/clear, set-wins rule, x0 tie-off), instantiated once. Forwarding priority select is a generate loop over NUM_SRC.

Test Plan:
- Reset mid-operation: pending[5]=1, count=7, assert reset_i asynchronously → pending_o=0 and stall_count_o=0 immediately, before the next edge.
- Stage priority: stage0 and stage1 both write x3 (ready=1), rs1=x3 → fwd_sel[0]=1, stall_o=0. Stage0 rd=x4 instead → fwd_sel[0]=2. rs=x0 with a stage writing x0 → sel 0.
- Load-use: stage0 rd=x7, ready=0, rs2=x7 → stall_o=1, counter +1 per cycle. Ready rises → stall_o=0, fwd_sel[1]=1.
- Long latency:
  - Issue with execute_rd=x9 → pending[9]=1 next cycle.
  - rs1=x9 → stall_o=1 until lat_complete_v_i with rd=x9; that cycle fwd_sel[0]=NUM_STAGES+1=3, stall_o=0, pending[9]=0 next cycle.
- Simultaneous and WAW:
  - Complete x9 and issue new x9 same cycle → pending[9] stays 1.
  - Execute rd=x9 while pending and not completing → stall_o=1 (WAW). Issued during stall → pending unaffected.
- Counter: hold stall 2^CNT_W+3 cycles (CNT_W=4 override) → saturates at 15. cnt_clear_i during stall → 0 next cycle.
